mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master arbiter for the picorv32 native memory interface. It shares one memory/peripheral slave port between master 0 (the CPU core) and master 1 (a secondary requester such as a loader or debug port) using round-robin arbitration. It allows one outstanding transaction at a time and has a response-timeout watchdog. It sits in `system` between the core's `mem_*` bus and the RAM/`out_byte` decode logic.

## Interface
Parameters:
- `TIMEOUT`, 1024: cycles a granted transaction may wait for `s_ready` before forced completion; 0 disables the watchdog.
- `ERR_DATA`, 32'hDEAD_BEEF: read data returned on a timed-out transaction.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `resetn`  in  1  synchronous active-low reset.
- `m0_valid`, `m1_valid`  in  1  request valid; the master holds it until its `mN_ready`.
- `m0_addr`, `m1_addr`  in  32  byte address.
- `m0_wdata`, `m1_wdata`  in  32  write data.
- `m0_wstrb`, `m1_wstrb`  in  4  byte write strobes; 0 means read.
- `m0_ready`, `m1_ready`  out  1  one-cycle completion pulse.
- `m0_rdata`, `m1_rdata`  out  32  read data; valid only while `mN_ready`=1.
- `s_valid`  out  1  slave request valid.
- `s_addr`  out  32  slave request address.
- `s_wdata`  out  32  slave request write data.
- `s_wstrb`  out  4  slave request write strobes.
- `s_ready`  in  1  slave completion.
- `s_rdata`  in  32  slave read data, sampled with `s_ready`.
- `grant`  out  1  index of the granted master; meaningful when `s_valid`=1.
- `bus_error`  out  1  one-cycle pulse when a transaction completes by timeout.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No `mN_valid` → stay in IDLE.
  - Exactly one `mN_valid` → latch `grant`=N and go to BUSY.
  - Both valid → grant `~last_grant`, go to BUSY.
- BUSY:
  - `s_valid`=1; `s_addr`/`s_wdata`/`s_wstrb` are muxed combinationally from the granted master.
  - Watchdog counter increments each cycle.
  - Completion when `s_ready`=1, or when the counter reaches `TIMEOUT`-1 with `TIMEOUT`≠0.
  - On completion: `m[grant]_ready`=1 in the same cycle. `m[grant]_rdata` = `s_rdata` (normal) or `ERR_DATA` (timeout). `bus_error`=1 on timeout only. `last_grant`←`grant`. Next state DONE.
- DONE: one dead cycle with `s_valid`=0, so the master can drop or re-present `valid` before re-arbitration; then go to IDLE.
- The non-granted master's `ready` is always 0. Its `rdata` is driven to 0.
- `s_ready` is ignored outside BUSY.
- A late `s_ready` after a timeout (during DONE or IDLE) is discarded.
- A master dropping `valid` mid-transaction is illegal; the arbiter still completes the latched transaction and does not abort it.
- Watchdog counter: $clog2(TIMEOUT+1) bits. It clears on entry to BUSY and does not wrap.

## Timing
- Reset values: `s_valid`=0, `m0_ready`=`m1_ready`=0, `bus_error`=0, `grant`=0, `last_grant`=1 (master 0 wins the first tie), state=IDLE, counter=0.
- Reset asserted mid-transaction: next edge goes to IDLE, `s_valid`=0 and no ready pulse is issued.
- Request latency: `mN_valid` rising at edge k (state IDLE) → `s_valid`=1 from edge k+1.
- Response latency: zero. `mN_ready` and `rdata` are combinational from `s_ready` in the same cycle.
- Back-to-back requests from one master: minimum spacing is 3 cycles (IDLE→BUSY→DONE) when the slave answers in the first BUSY cycle.
- Timeout completion occurs in the `TIMEOUT`-th BUSY cycle.
- Simultaneous `s_ready` and timeout in the same cycle: treated as normal completion (`s_rdata`, no `bus_error`).
- `grant` stays stable from IDLE→BUSY until the DONE→IDLE transition.

## Test plan
- Single read: m0 reads 0x0000_0010, slave returns 0x1234_5678 two cycles after `s_valid` → `m0_ready` 1-cycle pulse, `m0_rdata`=0x1234_5678, `s_wstrb`=0, `m1_ready` stays 0.
- Tie fairness: both masters continuously request (m0 reads 0x100, m1 writes 0xA5A5_A5A5 to 0x200 with `wstrb`=4'hF), slave ready in 1 cycle → grants alternate 0,1,0,1; slave sees 0xA5A5_A5A5 only with `grant`=1.
- Timeout: `TIMEOUT`=8, slave never asserts ready → `m1_ready`=1 and `bus_error`=1 in the 8th BUSY cycle, `m1_rdata`=0xDEAD_BEEF; a later stray `s_ready` produces no ready pulse.
- Ready coincides with timeout: `TIMEOUT`=4, `s_ready` in the 4th BUSY cycle with `s_rdata`=0x0000_00AA → normal completion, `bus_error`=0, `rdata`=0xAA.
- Reset mid-op: deassert `resetn` during BUSY → next cycle `s_valid`=0 and no ready pulse; the first tie after reset is granted to m0.
- Byte write to `out_byte` address 0x1000_0000 from m0 with `wstrb`=4'b0001, `wdata`=0x41 → slave sees exactly one `s_valid` transaction with these values and the bench prints "A".

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin two-master arbiter for the picorv32 native bus; one transaction in flight, response watchdog.
// Request reaches the slave one cycle after arbitration; completion is same-cycle; requesters wait while busy.
module mem_arbiter #(
    parameter int          TIMEOUT  = 1024,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic        grant,
    output logic        bus_error
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    state_t        state, state_nxt;
    logic          grant_nxt;
    logic          last_grant;
    logic [CW-1:0] cnt;
    logic          timed_out;
    logic          complete;
    logic          tout_done;
    logic [31:0]   rdata_sel;

    // Completion is gated by resetn so a reset landing mid-transaction never leaks a ready pulse.
    assign timed_out = (TIMEOUT != 0) && (cnt == CNT_LAST);
    assign complete  = (state == BUSY) && resetn && (s_ready || timed_out);
    assign tout_done = complete && !s_ready;

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        case (state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    state_nxt = BUSY;
                    if (m0_valid && m1_valid)
                        grant_nxt = ~last_grant;
                    else
                        grant_nxt = m1_valid;
                end
            end
            BUSY: begin
                if (complete)
                    state_nxt = DONE;
            end
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= IDLE;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            if (state == IDLE)
                cnt <= '0;
            else if (state == BUSY && cnt != '1)
                cnt <= cnt + 1'b1;
            if (complete)
                last_grant <= grant;
        end
    end

    assign s_valid = (state == BUSY);
    assign s_addr  = grant ? m1_addr  : m0_addr;
    assign s_wdata = grant ? m1_wdata : m0_wdata;
    assign s_wstrb = grant ? m1_wstrb : m0_wstrb;

    assign rdata_sel = tout_done ? ERR_DATA : s_rdata;
    assign m0_ready  = complete && !grant;
    assign m1_ready  = complete && grant;
    assign m0_rdata  = m0_ready ? rdata_sel : 32'h0;
    assign m1_rdata  = m1_ready ? rdata_sel : 32'h0;
    assign bus_error = tout_done;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: instance u8 uses TIMEOUT=8, u4 uses TIMEOUT=4, both on the same stimulus.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_valid, m1_valid, s_ready;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata, s_rdata;
    logic [3:0]  m0_wstrb, m1_wstrb;

    logic        m0_ready, m1_ready, s_valid, grant, bus_error;
    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic [3:0]  s_wstrb;

    logic        q_m0_ready, q_m1_ready, q_s_valid, q_grant, q_bus_error;
    logic [31:0] q_m0_rdata, q_m1_rdata, q_s_addr, q_s_wdata;
    logic [3:0]  q_s_wstrb;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) u8 (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant(grant), .bus_error(bus_error)
    );

    mem_arbiter #(.TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)) u4 (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(q_m0_ready), .m0_rdata(q_m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(q_m1_ready), .m1_rdata(q_m1_rdata),
        .s_valid(q_s_valid), .s_addr(q_s_addr), .s_wdata(q_s_wdata), .s_wstrb(q_s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata), .grant(q_grant), .bus_error(q_bus_error)
    );

    // Inputs change 1ns after a rising edge; outputs are sampled on the falling edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        s_ready  = 0; s_rdata = 0;
    endtask

    task automatic do_reset();
        resetn = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 resetn = 1;
    endtask

    task automatic test_reset();
        resetn = 0;
        clear_inputs();
        repeat (2) @(posedge clk);
        smp();
        tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL reset_s_valid: got %b want 0", s_valid); end
        tests++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b%b want 00", m0_ready, m1_ready); end
        tests++; if (bus_error !== 1'b0) begin fails++; $display("FAIL reset_bus_error: got %b want 0", bus_error); end
        tests++; if (grant !== 1'b0) begin fails++; $display("FAIL reset_grant: got %b want 0", grant); end
        nxt();
        resetn = 1;
    endtask

    task automatic test_single_read();
        do_reset();
        m0_valid = 1; m0_addr = 32'h0000_0010; m0_wstrb = 4'h0;
        smp();
        tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL read_idle_s_valid: got %b want 0", s_valid); end
        for (int c = 1; c <= 3; c++) begin
            nxt();
            if (c == 3) begin s_ready = 1; s_rdata = 32'h1234_5678; end
            smp();
            tests++; if (s_valid !== 1'b1 || s_addr !== 32'h10 || s_wstrb !== 4'h0 || grant !== 1'b0) begin
                fails++; $display("FAIL read_req c%0d: got v=%b a=%h st=%h g=%b want v=1 a=00000010 st=0 g=0", c, s_valid, s_addr, s_wstrb, grant);
            end
            tests++; if (m0_ready !== (c == 3) || m1_ready !== 1'b0) begin
                fails++; $display("FAIL read_ready c%0d: got m0=%b m1=%b want m0=%b m1=0", c, m0_ready, m1_ready, c == 3);
            end
        end
        tests++; if (m0_rdata !== 32'h1234_5678 || bus_error !== 1'b0) begin
            fails++; $display("FAIL read_rdata: got %h err=%b want 12345678 err=0", m0_rdata, bus_error);
        end
        nxt();
        s_ready = 0; s_rdata = 0; m0_valid = 0;
        smp();
        tests++; if (s_valid !== 1'b0 || m0_ready !== 1'b0) begin fails++; $display("FAIL read_done: got v=%b r=%b want 0 0", s_valid, m0_ready); end
        nxt();
    endtask

    task automatic test_tie_fairness();
        logic [31:0] exp_addr, exp_wdata;
        do_reset();
        m0_valid = 1; m0_addr = 32'h100; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        m1_valid = 1; m1_addr = 32'h200; m1_wdata = 32'hA5A5_A5A5; m1_wstrb = 4'hF;
        s_ready = 1; s_rdata = 32'h0000_5555;
        for (int t = 0; t < 4; t++) begin
            exp_addr  = t[0] ? 32'h200 : 32'h100;
            exp_wdata = t[0] ? 32'hA5A5_A5A5 : 32'h0;
            smp();
            tests++; if (s_valid !== 1'b0) begin fails++; $display("FAIL tie_idle t%0d: s_valid got %b want 0", t, s_valid); end
            nxt(); smp();
            tests++; if (s_valid !== 1'b1 || grant !== t[0] || s_addr !== exp_addr || s_wdata !== exp_wdata) begin
                fails++; $display("FAIL tie_grant t%0d: got g=%b a=%h d=%h want g=%b a=%h d=%h", t, grant, s_addr, s_wdata, t[0], exp_addr, exp_wdata);
            end
            tests++; if (m0_ready !== !t[0] || m1_ready !== t[0]) begin
                fails++; $display("FAIL tie_ready t%0d: got m0=%b m1=%b want m0=%b m1=%b", t, m0_ready, m1_ready, !t[0], t[0]);
            end
            nxt(); smp();
            tests++; if (s_valid !== 1'b0 || m0_ready !== 1'b0 || m1_ready !== 1'b0) begin
                fails++; $display("FAIL tie_done t%0d: got v=%b r=%b%b want 0 00", t, s_valid, m0_ready, m1_ready);
            end
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_timeout();
        do_reset();
        m1_valid = 1; m1_addr = 32'h300; m1_wstrb = 4'h0;
        for (int c = 1; c <= 8; c++) begin
            nxt(); smp();
            tests++; if (m1_ready !== (c == 8) || bus_error !== (c == 8) || m0_ready !== 1'b0) begin
                fails++; $display("FAIL timeout c%0d: got r=%b err=%b m0=%b want r=%b err=%b m0=0", c, m1_ready, bus_error, m0_ready, c == 8, c == 8);
            end
        end
        tests++; if (m1_rdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL timeout_rdata: got %h want deadbeef", m1_rdata); end
        nxt();
        m1_valid = 0; s_ready = 1; s_rdata = 32'h1111_1111;
        for (int c = 0; c < 2; c++) begin
            smp();
            tests++; if (m0_ready !== 1'b0 || m1_ready !== 1'b0 || bus_error !== 1'b0 || s_valid !== 1'b0) begin
                fails++; $display("FAIL stray_ready c%0d: got r=%b%b err=%b v=%b want 00 0 0", c, m0_ready, m1_ready, bus_error, s_valid);
            end
            nxt();
        end
        clear_inputs();
    endtask

    task automatic test_ready_at_timeout();
        do_reset();
        m0_valid = 1; m0_addr = 32'h400; m0_wstrb = 4'h0;
        for (int c = 1; c <= 4; c++) begin
            nxt();
            if (c == 4) begin s_ready = 1; s_rdata = 32'h0000_00AA; end
            smp();
            tests++; if (q_m0_ready !== (c == 4) || q_bus_error !== 1'b0) begin
                fails++; $display("FAIL coincide c%0d: got r=%b err=%b want r=%b err=0", c, q_m0_ready, q_bus_error, c == 4);
            end
        end
        tests++; if (q_m0_rdata !== 32'h0000_00AA) begin fails++; $display("FAIL coincide_rdata: got %h want 000000aa", q_m0_rdata); end
        nxt();
        clear_inputs();
        nxt();
    endtask

    task automatic test_reset_midop();
        do_reset();
        m0_valid = 1; s_ready = 1; s_rdata = 32'h7;
        nxt();
        nxt();
        m0_valid = 0; s_ready = 0;
        nxt();
        m1_valid = 1; m1_addr = 32'h500;
        nxt(); smp();
        tests++; if (s_valid !== 1'b1 || grant !== 1'b1) begin fails++; $display("FAIL midop_busy: got v=%b g=%b want 1 1", s_valid, grant); end
        nxt();
        resetn = 0; s_ready = 1;
        smp();
        tests++; if (m1_ready !== 1'b0 || m0_ready !== 1'b0) begin fails++; $display("FAIL midop_reset_ready: got %b%b want 00", m0_ready, m1_ready); end
        nxt(); smp();
        tests++; if (s_valid !== 1'b0 || m1_ready !== 1'b0 || m0_ready !== 1'b0) begin
            fails++; $display("FAIL midop_after_reset: got v=%b r=%b%b want 0 00", s_valid, m0_ready, m1_ready);
        end
        nxt();
        resetn = 1; s_ready = 0; m0_valid = 1; m1_valid = 1;
        nxt(); smp();
        tests++; if (s_valid !== 1'b1 || grant !== 1'b0) begin fails++; $display("FAIL midop_first_tie: got v=%b g=%b want 1 0", s_valid, grant); end
        nxt();
        s_ready = 1;
        nxt();
        clear_inputs();
        nxt();
    endtask

    task automatic test_byte_write();
        int txn;
        logic [7:0] ch;
        txn = 0;
        do_reset();
        m0_valid = 1; m0_addr = 32'h1000_0000; m0_wdata = 32'h41; m0_wstrb = 4'b0001;
        nxt();
        s_ready = 1;
        smp();
        if (s_valid) txn++;
        tests++; if (s_addr !== 32'h1000_0000 || s_wdata !== 32'h41 || s_wstrb !== 4'b0001 || m0_ready !== 1'b1) begin
            fails++; $display("FAIL bytewr_req: got a=%h d=%h st=%b r=%b want 10000000 00000041 0001 1", s_addr, s_wdata, s_wstrb, m0_ready);
        end
        ch = s_wdata[7:0];
        $display("%s", ch);
        nxt();
        m0_valid = 0; s_ready = 0;
        for (int c = 0; c < 4; c++) begin
            smp();
            if (s_valid) txn++;
            nxt();
        end
        tests++; if (txn !== 1) begin fails++; $display("FAIL bytewr_count: got %0d transactions want 1", txn); end
        clear_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        clear_inputs();
        resetn = 0;
        test_reset();
        test_single_read();
        test_tie_fairness();
        test_timeout();
        test_ready_at_timeout();
        test_reset_midop();
        test_byte_write();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
